// File: rtl/cpu_pkg.sv
// cpu_pkg: register-file widths, the zero-register index and the shared address/data types.
package cpu_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;
  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;
  localparam reg_addr_t ZERO_REG = '0;
endpackage

// File: rtl/regfile_if.sv
// regfile_if: write port and two read ports of the register file.
interface regfile_if;
  import cpu_pkg::*;
  logic      we;
  reg_addr_t waddr;
  reg_data_t wdata;
  reg_addr_t raddr_a;
  reg_addr_t raddr_b;
  reg_data_t rdata_a;
  reg_data_t rdata_b;
  modport master (output we, waddr, wdata, raddr_a, raddr_b, input rdata_a, rdata_b);
  modport slave  (input we, waddr, wdata, raddr_a, raddr_b, output rdata_a, rdata_b);
endinterface

// File: rtl/decoder_5to32.sv
// decoder_5to32: gated one-hot decode of a register index.
module decoder_5to32
  import cpu_pkg::*;
(
  input  reg_addr_t           idx_i,
  input  logic                en_i,
  output logic [NUM_REGS-1:0] onehot_o
);
  assign onehot_o = en_i ? NUM_REGS'(1) << idx_i : '0;
endmodule

// File: rtl/en_reg.sv
// en_reg: enabled register with asynchronous active-high clear.
module en_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  always_ff @(posedge clk or posedge clr)
    if (clr) q_o <= '0;
    else if (en_i) q_o <= d_i;
endmodule

// File: rtl/regfile.sv
// regfile: 32x32 register file, one sync write port, two async read ports, r0 hardwired to zero.
// REGFILE_BYPASS_EN forwards same-cycle write data to matching read ports.
module regfile
  import cpu_pkg::*;
(
  input  logic     clk,
  input  logic     clr,
  regfile_if.slave rf
);
  logic [NUM_REGS-1:0] dec;
  logic                unused_dec0;
  reg_data_t           regs [NUM_REGS];
  decoder_5to32 u_dec (.idx_i(rf.waddr), .en_i(rf.we), .onehot_o(dec));
  assign unused_dec0 = dec[0];
  assign regs[0] = '0;
  for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
    en_reg #(.W(DATA_W)) u_reg (
      .clk (clk),
      .clr (clr),
      .en_i(dec[i]),
      .d_i (rf.wdata),
      .q_o (regs[i])
    );
  end
`ifdef REGFILE_BYPASS_EN
  logic wr_live;
  assign wr_live    = rf.we && rf.waddr != ZERO_REG;
  // clr must win over forwarding so reads stay zero during reset
  assign rf.rdata_a = clr ? '0 : (wr_live && rf.raddr_a == rf.waddr) ? rf.wdata : regs[rf.raddr_a];
  assign rf.rdata_b = clr ? '0 : (wr_live && rf.raddr_b == rf.waddr) ? rf.wdata : regs[rf.raddr_b];
`else
  assign rf.rdata_a = regs[rf.raddr_a];
  assign rf.rdata_b = regs[rf.raddr_b];
`endif
endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed scoreboard bench for regfile.
module tb_regfile;
  import cpu_pkg::*;
  logic clk = 0;
  logic clr;
  int tests = 0;
  int fails = 0;
  reg_data_t model [NUM_REGS];
  reg_data_t sb [$];
  regfile_if rf ();
  regfile dut (.clk(clk), .clr(clr), .rf(rf));
  always #5 clk = ~clk;
  task automatic cmp(input string tag, input reg_data_t got);
    reg_data_t exp;
    exp = sb.pop_front();
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic rd(input string tag, input reg_addr_t ra, input reg_addr_t rb, input reg_data_t ea, input reg_data_t eb);
    rf.raddr_a = ra;
    rf.raddr_b = rb;
    sb.push_back(ea);
    sb.push_back(eb);
    #1;
    cmp({tag, "_a"}, rf.rdata_a);
    cmp({tag, "_b"}, rf.rdata_b);
  endtask
  task automatic wr(input reg_addr_t a, input reg_data_t d, input logic en);
    @(negedge clk);
    rf.we = en;
    rf.waddr = a;
    rf.wdata = d;
    @(posedge clk);
    #1 rf.we = 0;
    if (en && a != 0) model[a] = d;
  endtask
  task automatic clear_model();
    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
  endtask
  initial begin
    clear_model();
    clr = 1;
    rf.we = 0;
    rf.waddr = 0;
    rf.wdata = 0;
    rf.raddr_a = 0;
    rf.raddr_b = 0;
    #2 rd("reset", 5, 31, 32'h0, 32'h0);
    @(negedge clk) clr = 0;
    rd("never_written", 12, 1, 32'h0, 32'h0);
    wr(5, 32'hDEADBEEF, 1);
    rd("r5_written", 5, 5, 32'hDEADBEEF, 32'hDEADBEEF);
    #2 clr = 1;
    rd("async_clr", 5, 5, 32'h0, 32'h0);
    clear_model();
    @(negedge clk) clr = 0;
    rd("after_clr", 5, 0, 32'h0, 32'h0);
    for (int i = 1; i < NUM_REGS; i++) wr(reg_addr_t'(i), 32'h1000_0000 + i, 1);
    for (int i = 0; i < NUM_REGS; i++)
      rd($sformatf("sweep%0d", i), reg_addr_t'(i), reg_addr_t'(31 - i), model[i], model[31 - i]);
    wr(0, 32'hFFFFFFFF, 1);
    rd("zero_reg", 0, 1, 32'h0, 32'h1000_0001);
    for (int i = 1; i < NUM_REGS; i += 2)
      rd($sformatf("after_r0_wr%0d", i), reg_addr_t'(i), reg_addr_t'(i + 1), model[i], i == 31 ? 32'h0 : model[i + 1]);
    wr(7, 32'h12345678, 1);
    for (int k = 0; k < 3; k++) wr(7, 32'hAAAAAAAA, 0);
    rd("we_gate", 7, 7, 32'h12345678, 32'h12345678);
    wr(9, 32'h11, 1);
    @(negedge clk);
    rf.we = 1;
    rf.waddr = 9;
    rf.wdata = 32'h22;
`ifdef REGFILE_BYPASS_EN
    rd("rdw_before", 9, 9, 32'h22, 32'h22);
`else
    rd("rdw_before", 9, 9, 32'h11, 32'h11);
`endif
    @(posedge clk);
    #1 rf.we = 0;
    model[9] = 32'h22;
    rd("rdw_after", 9, 9, 32'h22, 32'h22);
    @(negedge clk);
    clr = 1;
    rf.we = 1;
    rf.waddr = 3;
    rf.wdata = 32'h55;
    rd("clr_vs_bypass", 3, 7, 32'h0, 32'h0);
    @(posedge clk);
    #1 rd("clr_vs_write_hold", 3, 9, 32'h0, 32'h0);
    @(negedge clk);
    rf.we = 0;
    clr = 0;
    clear_model();
    rd("clr_vs_write", 3, 31, 32'h0, 32'h0);
    wr(3, 32'h77, 1);
    rd("first_write_after_clr", 3, 2, 32'h77, 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/regfile.md
Name: regfile

Overview:
- 32-entry x 32-bit register file for the CPU: one synchronous write port, two asynchronous read ports.
- Built from 31 instances of the team's 32-bit enabled/clearable register; entry 0 is a hardwired zero.
- Sits between the writeback stage, which drives the write port, and decode/execute, which consume the read data.

Parameters:
- DATA_W, 32, width of each register and of all data ports.
- ADDR_W, 5, register index width.
- NUM_REGS, 32, number of architectural registers (2**ADDR_W).

Ports:
- clk  input  1  clock; all writes occur on its rising edge.
- clr  input  1  asynchronous, active-high reset; clears every register.
- we  input  1  write enable.
- waddr  input  ADDR_W  write register index.
- wdata  input  DATA_W  write data.
- raddr_a  input  ADDR_W  read port A index.
- raddr_b  input  ADDR_W  read port B index.
- rdata_a  output  DATA_W  read port A data.
- rdata_b  output  DATA_W  read port B data.

Behaviour:
- Clock and reset: one clock (clk). Reset (clr) is asynchronous and active-high.
- Reset:
  - clr high immediately forces registers 1..31 to 0, independent of clk.
  - rdata_a and rdata_b therefore read 0 for every address while clr is high.
  - clr dominates we: a write coincident with clr is lost.
  - Deasserting clr mid-operation leaves all registers 0; the first write takes effect on the next rising edge with we=1.
- Write:
  - On rising clk with we=1 and waddr!=0, register[waddr] <= wdata.
  - Write latency is 1 cycle; the value is visible on the read ports after that edge.
  - we=0 leaves all registers unchanged.
  - waddr=0 writes nothing.
- Write decode:
  - One-hot 5-to-32 decode of waddr, ANDed with we, drives the per-register en.
  - Bit 0 of the decode is unused.
  - Exactly one register, or none, is enabled per cycle.
- Read:
  - Purely combinational from raddr and stored state; zero-cycle latency.
  - raddr=0 always returns 0, even after an attempted write to 0.
  - Ports A and B are independent; the same address on both returns identical data.
- Read-during-write, same address, without bypass: the read port returns the OLD value until the clock edge, then the new value.
- X-handling: a read of an address never written since reset returns 0, never X.

Optional Feature:
- Macro: REGFILE_BYPASS_EN
- Defined:
  - If we=1, waddr!=0 and raddr_x==waddr, rdata_x = wdata combinationally, in the same cycle as the write.
  - Applies to both ports independently.
  - clr high still forces read data to 0, overriding bypass.
  - Removes the writeback-to-decode hazard.
- Undefined: read-during-write returns the stored (old) value as described above; no extra logic is generated.

Decomposition:
- Shared package cpu_pkg holds:
  - DATA_W, ADDR_W and NUM_REGS constants.
  - ZERO_REG index constant (0).
  - Typedefs reg_addr_t (ADDR_W bits) and reg_data_t (DATA_W bits).
- One natural sub-module: decoder_5to32 (5-bit index plus enable in, 32-bit one-hot out).
  - Used for the write decode.
  - Optionally reused for the read-select decode if reads are built as per-register select gating rather than muxes.
- Registers: 31 instances of the existing 32-bit register, generated in a loop over indices 1..31.

Test Plan:
- Reset: pulse clr mid-cycle, asynchronously, after writing 0xDEADBEEF to r5 -> rdata_a (raddr_a=5) reads 0x00000000 immediately, before the next clk edge.
- Write/read all: write value 0x1000_0000+i to ri for i=1..31, then sweep raddr_a 0..31 and raddr_b 31..0.
  - Each port returns 0x1000_0000+i for ri and 0 for r0.
- Zero register: we=1, waddr=0, wdata=0xFFFFFFFF -> rdata_a(raddr_a=0) = 0 on the next cycle; no other register changes.
- we gating: set r7=0x12345678, then present waddr=7, wdata=0xAAAAAAAA with we=0 for 3 cycles -> r7 remains 0x12345678.
- Read-during-write: r9=0x11, then in the same cycle we=1, waddr=9, wdata=0x22, raddr_a=raddr_b=9.
  - Without macro: both ports read 0x11 before the edge and 0x22 after.
  - With REGFILE_BYPASS_EN: both ports read 0x22 before the edge.
- clr vs write: assert clr and we=1 (waddr=3, wdata=0x55) across a clk edge, then release clr -> r3 reads 0.
